// File: rtl/tank_level_sequencer_if.sv
// tank_level_sequencer_if
// Groups the request inputs and status outputs of the tank level sequencer.
//   master : requester side; drives fill_req, drain_req, stop and
//            observes level, dir, step, pump_on, valve_open, full, empty, busy
//   slave  : the sequencer itself (the reverse directions)
interface tank_level_sequencer_if;
    logic       fill_req;
    logic       drain_req;
    logic       stop;
    logic [2:0] level;
    logic       dir;
    logic       step;
    logic       pump_on;
    logic       valve_open;
    logic       full;
    logic       empty;
    logic       busy;

    modport master (
        output fill_req, drain_req, stop,
        input  level, dir, step, pump_on, valve_open, full, empty, busy
    );

    modport slave (
        input  fill_req, drain_req, stop,
        output level, dir, step, pump_on, valve_open, full, empty, busy
    );
endinterface

// File: rtl/tank_level_sequencer.sv
// tank_level_sequencer
// Turns fill/drain requests into a paced level count 0..MAX_LEVEL for the
// water-tank display, and drives the pump/valve enables.
//
// Parameters:
//   STEP_DIV  : clock cycles per level step (>= 1)
//   MAX_LEVEL : top level, 1..7
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tank_level_sequencer_if.slave
//           in : fill_req, drain_req, stop
//           out: level[2:0], dir, step, pump_on, valve_open, full, empty, busy
// Build option:
//   AUTO_REFILL_EN : when defined, an empty idle tank starts filling by
//                    itself unless stop or drain_req is held.
module tank_level_sequencer #(
    parameter int STEP_DIV  = 4,
    parameter int MAX_LEVEL = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tank_level_sequencer_if.slave  bus
);

    localparam int             CW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(STEP_DIV - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [2:0]     LEVEL_TOP = 3'(MAX_LEVEL);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        COOLDOWN
    } state_t;

    state_t         state, state_next;
    logic [2:0]     level, level_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           dir, dir_next;
    logic           step, step_next;

    logic           is_full;
    logic           is_empty;
    logic           div_wrap;
    logic           start_fill;

    assign is_full  = (level == LEVEL_TOP);
    assign is_empty = (level == 3'd0);
    assign div_wrap = (cnt == CNT_LAST);

    // Fill entry condition; the auto-refill build also starts on an empty
    // tank, but a held stop or drain_req keeps it parked in IDLE.
`ifdef AUTO_REFILL_EN
    assign start_fill = (bus.fill_req || (is_empty && !bus.stop && !bus.drain_req)) && !is_full;
`else
    assign start_fill = bus.fill_req && !is_full;
`endif

    // State, level, divider, direction and step registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            level <= 3'd0;
            cnt   <= '0;
            dir   <= 1'b0;
            step  <= 1'b0;
        end else begin
            state <= state_next;
            level <= level_next;
            cnt   <= cnt_next;
            dir   <= dir_next;
            step  <= step_next;
        end
    end

    // Next-state logic. stop is checked before the divider wrap so an abort
    // never produces a final level change. The same divider times the
    // cooldown, which therefore lasts exactly STEP_DIV cycles.
    always_comb begin
        state_next = state;
        level_next = level;
        cnt_next   = cnt;
        dir_next   = dir;
        step_next  = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (start_fill) begin
                    state_next = FILL;
                    dir_next   = 1'b1;
                end else if (bus.drain_req && !is_empty) begin
                    state_next = DRAIN;
                    dir_next   = 1'b0;
                end
            end

            FILL: begin
                if (bus.stop) begin
                    state_next = COOLDOWN;
                    cnt_next   = '0;
                end else if (div_wrap) begin
                    level_next = level + 3'd1;
                    cnt_next   = '0;
                    step_next  = 1'b1;
                    if (level + 3'd1 == LEVEL_TOP) begin
                        state_next = COOLDOWN;
                    end
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            DRAIN: begin
                if (bus.stop) begin
                    state_next = COOLDOWN;
                    cnt_next   = '0;
                end else if (div_wrap) begin
                    level_next = level - 3'd1;
                    cnt_next   = '0;
                    step_next  = 1'b1;
                    if (level == 3'd1) begin
                        state_next = COOLDOWN;
                    end
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            COOLDOWN: begin
                if (div_wrap) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign bus.level      = level;
    assign bus.dir        = dir;
    assign bus.step       = step;
    assign bus.pump_on    = (state == FILL);
    assign bus.valve_open = (state == DRAIN);
    assign bus.busy       = (state != IDLE);
    assign bus.full       = is_full;
    assign bus.empty      = is_empty;

endmodule

// File: tb/tb_tank_level_sequencer.sv
// tb_tank_level_sequencer
// Table of hand-computed phases, a hand-written async reset sequence, and a
// randomized run against a behavioural model of the tank.
// Output vectors are packed as {level[2:0], dir, step, pump_on, valve_open,
// full, empty, busy}.
module tb_tank_level_sequencer;

    localparam int STEP_DIV  = 4;
    localparam int MAX_LEVEL = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tank_level_sequencer_if tif ();

    tank_level_sequencer #(
        .STEP_DIV  (STEP_DIV),
        .MAX_LEVEL (MAX_LEVEL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       fr;
        logic       dr;
        logic       st;
        int         cycles;
        logic [2:0] lvl;
        logic       dir;
        logic       step;
        logic       pump;
        logic       valve;
        logic       busy;
    } vec_t;

    vec_t vecs [35];

    // Behavioural model: mode 0 idle, 1 filling, 2 draining, 3 resting;
    // ticks counts whole cycles spent in the current mode.
    int m_mode;
    int m_level;
    int m_ticks;
    bit m_dir;
    bit m_step;

    task automatic modelReset();
        m_mode  = 0;
        m_level = 0;
        m_ticks = 0;
        m_dir   = 1'b0;
        m_step  = 1'b0;
    endtask

    task automatic modelAdvance(input bit fr, input bit dr, input bit st);
        bit want_fill;
        m_step = 1'b0;
        case (m_mode)
            0: begin
                want_fill = fr;
`ifdef AUTO_REFILL_EN
                if (m_level == 0 && !st && !dr) want_fill = 1'b1;
`endif
                if (want_fill && m_level < MAX_LEVEL) begin
                    m_mode = 1; m_dir = 1'b1; m_ticks = 0;
                end else if (dr && m_level > 0) begin
                    m_mode = 2; m_dir = 1'b0; m_ticks = 0;
                end
            end
            1, 2: begin
                if (st) begin
                    m_mode = 3; m_ticks = 0;
                end else begin
                    m_ticks++;
                    if (m_ticks % STEP_DIV == 0) begin
                        m_level = (m_mode == 1) ? m_level + 1 : m_level - 1;
                        m_step  = 1'b1;
                        if ((m_mode == 1 && m_level == MAX_LEVEL) || (m_mode == 2 && m_level == 0)) begin
                            m_mode = 3; m_ticks = 0;
                        end
                    end
                end
            end
            default: begin
                m_ticks++;
                if (m_ticks == STEP_DIV) begin
                    m_mode = 0; m_ticks = 0;
                end
            end
        endcase
    endtask

    function automatic logic [9:0] modelOutputs();
        return {3'(m_level), m_dir, m_step, (m_mode == 1), (m_mode == 2),
                (m_level == MAX_LEVEL), (m_level == 0), (m_mode != 0)};
    endfunction

    function automatic logic [9:0] dutOutputs();
        return {tif.level, tif.dir, tif.step, tif.pump_on, tif.valve_open,
                tif.full, tif.empty, tif.busy};
    endfunction

    function automatic logic [9:0] packExp(input logic [2:0] lvl, input logic dir, input logic step,
                                           input logic pump, input logic valve, input logic busy);
        return {lvl, dir, step, pump, valve, (lvl == 3'(MAX_LEVEL)), (lvl == 3'd0), busy};
    endfunction

    function automatic vec_t mk(input logic fr, input logic dr, input logic st, input int cycles,
                                input logic [2:0] lvl, input logic dir, input logic step,
                                input logic pump, input logic valve, input logic busy);
        vec_t v;
        v.fr = fr; v.dr = dr; v.st = st; v.cycles = cycles;
        v.lvl = lvl; v.dir = dir; v.step = step; v.pump = pump; v.valve = valve; v.busy = busy;
        return v;
    endfunction

    // One clock: the model consumes the inputs the DUT samples at this edge,
    // then outputs are settled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        modelAdvance(tif.fill_req, tif.drain_req, tif.stop);
        #1;
    endtask

    task automatic applyStimulus(input logic fr, input logic dr, input logic st, input int n);
        tif.fill_req  = fr;
        tif.drain_req = dr;
        tif.stop      = st;
        repeat (n) tick();
    endtask

    task automatic checkOutput(input string name, input logic [9:0] expected);
        logic [9:0] got;
        got = dutOutputs();
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %b expected %b (lvl,dir,step,pump,valve,full,empty,busy)",
                     name, got, expected);
        end
    endtask

    initial begin
        tif.fill_req  = 1'b0;
        tif.drain_req = 1'b0;
        tif.stop      = 1'b0;
        modelReset();

        // Phase table: inputs held for 'cycles' edges, then outputs checked.
        vecs[0]  = mk(1,0,0, 1, 3'd0,1,0,1,0,1);  // fill starts
        vecs[1]  = mk(0,0,0, 3, 3'd0,1,0,1,0,1);
        vecs[2]  = mk(0,0,0, 1, 3'd1,1,1,1,0,1);  // first step at N+4
        vecs[3]  = mk(0,0,0, 1, 3'd1,1,0,1,0,1);  // step is one cycle
        vecs[4]  = mk(0,0,0,23, 3'd7,1,1,0,0,1);  // full at N+28, cooldown
        vecs[5]  = mk(0,0,0, 3, 3'd7,1,0,0,0,1);
        vecs[6]  = mk(0,0,0, 1, 3'd7,1,0,0,0,0);  // idle after 4 cooldown cycles
        vecs[7]  = mk(1,0,0, 3, 3'd7,1,0,0,0,0);  // fill when full ignored
        vecs[8]  = mk(0,1,0, 1, 3'd7,0,0,0,1,1);  // drain starts
        vecs[9]  = mk(0,0,0,16, 3'd3,0,1,0,1,1);
        vecs[10] = mk(0,0,1, 1, 3'd3,0,0,0,0,1);  // stop to park at 3
        vecs[11] = mk(0,0,0, 3, 3'd3,0,0,0,0,1);
        vecs[12] = mk(0,0,0, 1, 3'd3,0,0,0,0,0);
        vecs[13] = mk(1,1,0, 1, 3'd3,1,0,1,0,1);  // fill wins arbitration
        vecs[14] = mk(0,1,0, 4, 3'd4,1,1,1,0,1);  // drain_req ignored in FILL
        vecs[15] = mk(0,1,1, 1, 3'd4,1,0,0,0,1);
        vecs[16] = mk(0,1,0, 4, 3'd4,1,0,0,0,0);  // requests ignored in cooldown
        vecs[17] = mk(1,0,0, 1, 3'd4,1,0,1,0,1);
        vecs[18] = mk(0,0,0, 4, 3'd5,1,1,1,0,1);
        vecs[19] = mk(0,0,1, 1, 3'd5,1,0,0,0,1);
        vecs[20] = mk(0,0,0, 4, 3'd5,1,0,0,0,0);
        vecs[21] = mk(0,1,0, 1, 3'd5,0,0,0,1,1);  // drain from 5
        vecs[22] = mk(0,0,0, 3, 3'd5,0,0,0,1,1);  // cnt now 3
        vecs[23] = mk(0,0,1, 1, 3'd5,0,0,0,0,1);  // stop beats the wrap
        vecs[24] = mk(0,0,0, 3, 3'd5,0,0,0,0,1);
        vecs[25] = mk(0,0,0, 1, 3'd5,0,0,0,0,0);
        vecs[26] = mk(0,1,0, 1, 3'd5,0,0,0,1,1);
        vecs[27] = mk(0,0,0,20, 3'd0,0,1,0,0,1);  // empty, cooldown
        vecs[28] = mk(0,0,0, 3, 3'd0,0,0,0,0,1);
        vecs[29] = mk(0,0,0, 1, 3'd0,0,0,0,0,0);
`ifdef AUTO_REFILL_EN
        vecs[30] = mk(0,0,0, 1, 3'd0,1,0,1,0,1);  // refill starts by itself
        vecs[31] = mk(0,1,0, 2, 3'd0,1,0,1,0,1);
        vecs[32] = mk(0,0,1, 1, 3'd0,1,0,0,0,1);
        vecs[33] = mk(0,0,1, 4, 3'd0,1,0,0,0,0);  // held stop parks it
        vecs[34] = mk(0,1,0, 2, 3'd0,1,0,0,0,0);  // drain_req at empty parks it
`else
        vecs[30] = mk(0,0,0, 1, 3'd0,0,0,0,0,0);  // empty tank stays empty
        vecs[31] = mk(0,1,0, 2, 3'd0,0,0,0,0,0);  // drain at empty ignored
        vecs[32] = mk(0,0,1, 1, 3'd0,0,0,0,0,0);
        vecs[33] = mk(0,0,1, 4, 3'd0,0,0,0,0,0);
        vecs[34] = mk(0,1,0, 2, 3'd0,0,0,0,0,0);
`endif

        #12;
        checkOutput("reset_state", packExp(3'd0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < 35; i++) begin
            applyStimulus(vecs[i].fr, vecs[i].dr, vecs[i].st, vecs[i].cycles);
            checkOutput($sformatf("vec_%0d", i),
                        packExp(vecs[i].lvl, vecs[i].dir, vecs[i].step,
                                vecs[i].pump, vecs[i].valve, vecs[i].busy));
        end

        // Asynchronous reset in the middle of a fill at level 3.
        applyStimulus(1, 0, 0, 1);
        checkOutput("rst_seq_start", packExp(3'd0, 1, 0, 1, 0, 1));
        applyStimulus(0, 0, 0, 12);
        checkOutput("rst_seq_level3", packExp(3'd3, 1, 1, 1, 0, 1));
        applyStimulus(0, 0, 0, 2);
        checkOutput("rst_seq_midfill", packExp(3'd3, 1, 0, 1, 0, 1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", packExp(3'd0, 0, 0, 0, 0, 0));
        modelReset();
        @(posedge clk);
        #3;
        checkOutput("reset_held", packExp(3'd0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // Randomized run against the model.
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 15) == 0, 1);
            checkOutput($sformatf("random_%0d", i), modelOutputs());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
